motor_drive_seq: RTL and testbench

- Sequences the smart-car drive datapath from decoded remote-key codes.
- Keeps a direction state machine for both H-bridge sides and a speed target selected by speed keys.
- Ramps the applied PWM duty toward the target (soft start/stop) and forces ramp-down plus dead time before any direction reversal.
- Generates glitch-free PWM for left and right motors, with a watchdog stop when keys stop arriving.

---
 rtl/motor_drive_seq.sv | 120 ++++++++++++
 tb/tb_motor_drive_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/motor_drive_seq.sv
// motor_drive_seq: remote-key drive sequencer with soft ramp, dead time before reversal, watchdog stop and PWM
module motor_drive_seq #(
  parameter int PWM_PERIOD = 5000,
  parameter int SPD_LO = 2000,
  parameter int SPD_MID = 2500,
  parameter int SPD_HI = 3500,
  parameter int RAMP_DIV = 50000,
  parameter int RAMP_STEP = 100,
  parameter int DEAD_CYC = 5000,
  parameter int TIMEOUT = 5500000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  key,
  input  logic        key_valid,
  output logic        pwm_l,
  output logic        pwm_r,
  output logic [1:0]  dir_l,
  output logic [1:0]  dir_r,
  output logic [12:0] duty,
  output logic [2:0]  state,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE = 3'd0, RAMP = 3'd1, RUN = 3'd2, STOPPING = 3'd3, DEAD = 3'd4} st_t;
  localparam int DW = $clog2(RAMP_DIV + 1);
  localparam int WW = $clog2(TIMEOUT + 2);
  localparam int XW = $clog2(DEAD_CYC + 1);
  st_t st, st_nx;
  logic [12:0] duty_nx, target, target_nx, kspd, diff, step, sstep, pcnt, cmp;
  logic [3:0] dirs, dirs_nx, pend, pend_nx, kdir;
  logic pend_v, pend_v_nx, is_stop, is_spd, kv, tick, run_ph, wd_exp;
  logic [DW-1:0] div;
  logic [WW-1:0] wd;
  logic [XW-1:0] dcnt;
  assign dir_l = dirs[3:2];
  assign dir_r = dirs[1:0];
  assign state = st;
  assign busy = st == RAMP || st == STOPPING || st == DEAD;
  always_comb begin
    kdir = key == 8'd24 ? 4'b0101 : key == 8'd82 ? 4'b1010 : key == 8'd8 ? 4'b1001 : key == 8'd90 ? 4'b0110 : 4'b0000;
    kspd = key == 8'd22 ? 13'(SPD_LO) : key == 8'd25 ? 13'(SPD_MID) : 13'(SPD_HI);
    is_stop = key == 8'd28;
    is_spd = key == 8'd22 || key == 8'd25 || key == 8'd13;
    kv = key_valid && (kdir != 4'b0 || is_stop || is_spd);
    // a key in the same cycle as a ramp tick swallows the tick
    tick = div == DW'(RAMP_DIV - 1) && !kv;
    run_ph = st == RAMP || st == RUN;
    wd_exp = run_ph && wd == WW'(TIMEOUT);
    diff = duty > target ? duty - target : target - duty;
    step = diff < 13'(RAMP_STEP) ? diff : 13'(RAMP_STEP);
    sstep = duty < 13'(RAMP_STEP) ? duty : 13'(RAMP_STEP);
    st_nx = st;
    duty_nx = duty;
    dirs_nx = dirs;
    pend_nx = pend;
    pend_v_nx = pend_v;
    target_nx = kv && is_spd ? kspd : target;
    if ((st == STOPPING || st == DEAD) && kv && !is_spd) begin
      pend_nx = kdir;
      pend_v_nx = !is_stop;
    end
    case (st)
      IDLE: if (kv && kdir != 4'b0) begin
        dirs_nx = kdir;
        st_nx = RAMP;
      end
      RAMP, RUN: if (kv && (is_stop || (kdir != 4'b0 && kdir != dirs))) begin
        pend_nx = kdir;
        pend_v_nx = !is_stop;
        st_nx = STOPPING;
      end else if (kv) st_nx = is_spd ? RAMP : st;
      else if (wd_exp) begin
        pend_v_nx = 1'b0;
        st_nx = STOPPING;
      end else if (st == RAMP && duty == target) st_nx = RUN;
      else if (st == RAMP && tick) duty_nx = duty > target ? duty - step : duty + step;
      STOPPING: if (duty == 13'd0) begin
        st_nx = DEAD;
        dirs_nx = 4'b0;
      end else if (tick) duty_nx = duty - sstep;
      DEAD: if (dcnt == XW'(DEAD_CYC - 1)) begin
        st_nx = pend_v_nx ? RAMP : IDLE;
        dirs_nx = pend_v_nx ? pend_nx : 4'b0;
        pend_v_nx = 1'b0;
      end
      default: st_nx = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st <= IDLE;
      duty <= '0;
      target <= 13'(SPD_MID);
      dirs <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      div <= '0;
      wd <= '0;
      dcnt <= '0;
      pcnt <= '0;
      cmp <= '0;
      pwm_l <= 1'b0;
      pwm_r <= 1'b0;
    end else begin
      st <= st_nx;
      duty <= duty_nx;
      target <= target_nx;
      dirs <= dirs_nx;
      pend <= pend_nx;
      pend_v <= pend_v_nx;
      div <= div == DW'(RAMP_DIV - 1) ? '0 : div + 1'b1;
      wd <= run_ph && !kv ? wd + 1'b1 : '0;
      dcnt <= st == DEAD ? dcnt + 1'b1 : '0;
      pcnt <= pcnt == 13'(PWM_PERIOD - 1) ? '0 : pcnt + 1'b1;
      if (pcnt == 13'(PWM_PERIOD - 1)) cmp <= duty;
      pwm_l <= pcnt < cmp;
      pwm_r <= pcnt < cmp;
    end
  end
endmodule

// File: tb/tb_motor_drive_seq.sv
// tb_motor_drive_seq: randomized scoreboard bench for motor_drive_seq against a timestamp-based reference model
module tb_motor_drive_seq;
  localparam int P = 100, SLO = 40, SMID = 50, SHI = 70, RD = 4, RS = 20, DC = 8, TO = 200;
  typedef struct packed {
    logic [2:0] st;
    logic [12:0] duty;
    logic [1:0] dl, dr;
    logic pl, pr, busy;
  } obs_t;
  logic sys_clk = 1'b0, sys_rst = 1'b1, key_valid = 1'b0;
  logic [7:0] key = 8'd0;
  logic pwm_l, pwm_r, busy;
  logic [1:0] dir_l, dir_r;
  logic [12:0] duty;
  logic [2:0] state;
  obs_t exp_q[$];
  int checks = 0, errors = 0, cycles = 0;
  int m_st, m_duty, m_tgt, m_dir, m_pv, m_pdir, m_cmp, m_pwm, m_n, m_wdm, m_dent;
  int kk;
  int keys[9] = '{24, 82, 8, 90, 28, 22, 25, 13, 7};

  motor_drive_seq #(.PWM_PERIOD(P), .SPD_LO(SLO), .SPD_MID(SMID), .SPD_HI(SHI), .RAMP_DIV(RD),
    .RAMP_STEP(RS), .DEAD_CYC(DC), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key(key), .key_valid(key_valid), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .dir_l(dir_l), .dir_r(dir_r), .duty(duty), .state(state), .busy(busy));

  always #5 sys_clk = ~sys_clk;

  // direction as left*4+right, bridge code 1=forward 2=reverse
  function automatic int key_dir(input int k);
    return k == 24 ? 1 * 4 + 1 : k == 82 ? 2 * 4 + 2 : k == 8 ? 2 * 4 + 1 : k == 90 ? 1 * 4 + 2 : 0;
  endfunction

  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction

  // m_n = edges since reset; divider, PWM counter, watchdog and dead time are derived from timestamps
  task automatic model_step(input bit r, input int k, input bit v);
    int s, d, t, kd, spd;
    bit rec, stop, tick, runp, expd;
    if (r) begin
      m_st = 0; m_duty = 0; m_tgt = SMID; m_dir = 0; m_pv = 0; m_pdir = 0;
      m_cmp = 0; m_pwm = 0; m_n = 0; m_wdm = 0; m_dent = 0;
      return;
    end
    m_n++;
    s = m_st; d = m_duty; t = m_tgt;
    kd = key_dir(k);
    stop = k == 28;
    spd = k == 22 ? SLO : k == 25 ? SMID : k == 13 ? SHI : -1;
    rec = v && (kd != 0 || stop || spd >= 0);
    tick = (m_n % RD == 0) && !rec;
    runp = s == 1 || s == 2;
    expd = runp && (m_n - 1 - m_wdm) == TO;
    if (!(runp && !rec)) m_wdm = m_n;
    m_pwm = ((m_n - 1) % P) < m_cmp ? 1 : 0;
    if (m_n % P == 0) m_cmp = d;
    if (rec && spd >= 0) m_tgt = spd;
    if ((s == 3 || s == 4) && rec && spd < 0) begin m_pv = stop ? 0 : 1; m_pdir = kd; end
    if (s == 0) begin
      if (rec && kd != 0) begin m_dir = kd; m_st = 1; end
    end else if (s == 1 || s == 2) begin
      if (rec && (stop || (kd != 0 && kd != m_dir))) begin m_pv = stop ? 0 : 1; m_pdir = kd; m_st = 3; end
      else if (rec) begin if (spd >= 0) m_st = 1; end
      else if (expd) begin m_pv = 0; m_st = 3; end
      else if (s == 1 && d == t) m_st = 2;
      else if (s == 1 && tick) m_duty = t > d ? d + imin(RS, t - d) : d - imin(RS, d - t);
    end else if (s == 3) begin
      if (d == 0) begin m_st = 4; m_dir = 0; m_dent = m_n; end
      else if (tick) m_duty = d - imin(RS, d);
    end else if (s == 4 && m_n - m_dent == DC) begin
      m_st = m_pv ? 1 : 0;
      m_dir = m_pv ? m_pdir : 0;
      m_pv = 0;
    end
  endtask

  task automatic cyc(input bit r, input int k, input bit v);
    obs_t e;
    @(negedge sys_clk);
    sys_rst = r; key = 8'(k); key_valid = v;
    model_step(r, k, v);
    e.st = 3'(m_st); e.duty = 13'(m_duty); e.dl = 2'(m_dir / 4); e.dr = 2'(m_dir % 4);
    e.pl = m_pwm[0]; e.pr = m_pwm[0]; e.busy = m_st == 1 || m_st == 3 || m_st == 4;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, $urandom_range(0, 255), 1'b0);
  endtask

  task automatic press(input int k);
    cyc(0, k, 1'b1);
  endtask

  task automatic wait_st(input int s, input int lim);
    for (int i = 0; i < lim && m_st != s; i++) idle(1);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge sys_clk);
      #1;
      cycles++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, duty, dir_l, dir_r, pwm_l, pwm_r, busy};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL obs cyc=%0d got st=%0d duty=%0d dir=%b/%b pwm=%b%b busy=%b want st=%0d duty=%0d dir=%b/%b pwm=%b%b busy=%b",
            cycles, a.st, a.duty, a.dl, a.dr, a.pl, a.pr, a.busy, e.st, e.duty, e.dl, e.dr, e.pl, e.pr, e.busy);
        end
      end
    end
  end

  initial begin
    repeat (3) cyc(1, 0, 1'b0);
    press(24); idle(150); press(24); idle(100);
    press(13); idle(30); press(22); idle(40);
    press(82); wait_st(4, 100); idle(40);
    press(24); wait_st(4, 100); idle(2); press(8); idle(2); press(28); idle(20);
    press(24); idle(420);
    press(24);
    for (int i = 0; i < RD && (m_n + 1) % RD != 0; i++) idle(1);
    press(25); idle(2); cyc(1, 0, 1'b0); idle(10);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) cyc(1, 0, 1'b0);
      else if ($urandom_range(0, 29) == 0) begin
        kk = keys[$urandom_range(0, 8)];
        if (kk == 7) kk = $urandom_range(0, 255);
        press(kk);
      end else idle(1);
    end
    repeat (3) @(posedge sys_clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
